// File: rtl/rtlola_eval_scheduler.sv
// Front-end scheduler for the RTLola monitor pipeline: timestamps and buffers input
// events, generates periodic deadlines, and issues one in-order evaluation slot at a time.
module rtlola_eval_scheduler #(
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 4,
    parameter int PERIOD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   input_x,
    input  logic                       new_input,
    input  logic                       clr_flags,
    input  logic                       pipe_ready,
    output logic                       issue_valid,
    output logic                       issue_event,
    output logic                       issue_periodic,
    output logic signed [DATA_W-1:0]   issue_data,
    output logic [TS_W-1:0]            issue_ts,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic                       deadline_miss
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PERIOD);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);

    typedef enum logic {IDLE, HOLD} state_t;
    state_t state_reg, state_next;

    logic [TS_W-1:0]   ts_cnt_reg;
    logic [TS_W-1:0]   dl_ts_reg;
    logic [PW-1:0]     per_cnt_reg;
    logic              pending_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW:0]       count_reg;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TS_W-1:0]   mem_ts [DEPTH];
    logic              ev_reg;
    logic              per_reg;
    logic [DATA_W-1:0] data_reg;
    logic [TS_W-1:0]   ts_reg;
    logic              ovf_reg;
    logic              miss_reg;

    // Wrap-aware ordering: a precedes b when (a-b) is negative modulo 2^TS_W.
    function automatic logic ts_lt(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
        logic [TS_W-1:0] diff;
        diff = a - b;
        return diff[TS_W-1];
    endfunction

    logic              consume;
    logic              deq;
    logic              cons_p;
    logic [AW:0]       avail;
    logic [AW-1:0]     sel_ptr;
    logic              cand_ev;
    logic              cand_p;
    logic [TS_W-1:0]   head_ts;
    logic [DATA_W-1:0] head_data;
    logic              take_ev;
    logic              take_p;
    logic              load;
    logic              fire;
    logic              miss_hit;
    logic              full;
    logic              enq;
    logic              drop;

    // The held slot still occupies the FIFO head / pending deadline until it is consumed,
    // so the next candidate must look past whatever the consumed slot carried.
    assign consume   = en && (state_reg == HOLD) && pipe_ready;
    assign deq       = consume && ev_reg;
    assign cons_p    = consume && per_reg;
    assign avail     = count_reg - (AW+1)'(deq);
    assign sel_ptr   = deq ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    assign cand_ev   = (avail != '0);
    assign cand_p    = pending_reg && !cons_p;
    assign head_ts   = mem_ts[sel_ptr];
    assign head_data = mem_data[sel_ptr];
    assign take_ev   = cand_ev && (!cand_p || !ts_lt(dl_ts_reg, head_ts));
    assign take_p    = cand_p && (!cand_ev || !ts_lt(head_ts, dl_ts_reg));
    assign load      = en && ((state_reg == IDLE) || consume) && (cand_ev || cand_p);

    assign fire      = en && (per_cnt_reg == PER_LAST);
    assign miss_hit  = fire && pending_reg && !cons_p;
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign enq       = en && new_input && (!full || deq);
    assign drop      = en && new_input && full && !deq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = HOLD;
            HOLD:    if (consume && !load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_data[wr_ptr_reg] <= input_x;
            mem_ts[wr_ptr_reg]   <= ts_cnt_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt_reg  <= '0;
            dl_ts_reg   <= '0;
            per_cnt_reg <= '0;
            pending_reg <= 1'b0;
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            ev_reg      <= 1'b0;
            per_reg     <= 1'b0;
            data_reg    <= '0;
            ts_reg      <= '0;
            ovf_reg     <= 1'b0;
            miss_reg    <= 1'b0;
        end else if (en) begin
            ts_cnt_reg  <= ts_cnt_reg + TS_W'(1);
            per_cnt_reg <= fire ? '0 : per_cnt_reg + PW'(1);

            // A miss keeps the older deadline; consuming at the firing edge re-arms cleanly.
            if (fire && !miss_hit) begin
                pending_reg <= 1'b1;
                dl_ts_reg   <= ts_cnt_reg;
            end else if (cons_p) begin
                pending_reg <= 1'b0;
            end

            miss_reg <= (miss_reg && !clr_flags) || miss_hit;
            ovf_reg  <= (ovf_reg && !clr_flags) || drop;

            if (enq) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (deq) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(enq) - (AW+1)'(deq);

            if (load) begin
                ev_reg   <= take_ev;
                per_reg  <= take_p;
                data_reg <= take_ev ? head_data : '0;
                ts_reg   <= take_ev ? head_ts : dl_ts_reg;
            end else if (consume) begin
                ev_reg  <= 1'b0;
                per_reg <= 1'b0;
            end
        end
    end

    assign issue_valid    = (state_reg == HOLD);
    assign issue_event    = ev_reg;
    assign issue_periodic = per_reg;
    assign issue_data     = data_reg;
    assign issue_ts       = ts_reg;
    assign fifo_level     = count_reg;
    assign overflow       = ovf_reg;
    assign deadline_miss  = miss_reg;

endmodule

// File: tb/tb_rtlola_eval_scheduler.sv
// Directed bench for rtlola_eval_scheduler: a per-cycle vector table from reset plus
// hand-written sequences for overflow, deadline miss, mid-operation reset and enable.
module tb_rtlola_eval_scheduler;
    localparam int DATA_W = 64;
    localparam int TS_W   = 32;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     en = 1'b0;
    logic signed [DATA_W-1:0] input_x = '0;
    logic                     new_input = 1'b0;
    logic                     clr_flags = 1'b0;
    logic                     pipe_ready = 1'b0;
    logic                     issue_valid;
    logic                     issue_event;
    logic                     issue_periodic;
    logic signed [DATA_W-1:0] issue_data;
    logic [TS_W-1:0]          issue_ts;
    logic [2:0]               fifo_level;
    logic                     overflow;
    logic                     deadline_miss;

    int checks = 0;
    int errors = 0;

    rtlola_eval_scheduler #(
        .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH), .PERIOD(PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .input_x(input_x), .new_input(new_input),
        .clr_flags(clr_flags), .pipe_ready(pipe_ready), .issue_valid(issue_valid),
        .issue_event(issue_event), .issue_periodic(issue_periodic), .issue_data(issue_data),
        .issue_ts(issue_ts), .fifo_level(fifo_level), .overflow(overflow),
        .deadline_miss(deadline_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ni;
        logic [63:0] x;
        logic        rdy;
        logic        clr;
        logic        v;
        logic        ev;
        logic        p;
        logic [63:0] d;
        logic [31:0] ts;
        logic [2:0]  lvl;
        logic        o;
        logic        m;
    } vec_t;

    vec_t tbl[26];

    // Slot fields are only meaningful while a slot is presented.
    task automatic check_out(input string name, input logic v, input logic ev, input logic p,
                             input logic [63:0] d, input logic [31:0] ts, input logic [2:0] lvl,
                             input logic o, input logic m);
        logic ok;
        checks++;
        ok = (issue_valid === v) && (fifo_level === lvl) && (overflow === o) && (deadline_miss === m);
        if (v) ok = ok && (issue_event === ev) && (issue_periodic === p)
                       && (issue_data === d) && (issue_ts === ts);
        if (!ok) begin
            errors++;
            $display("FAIL %s: got v=%0b ev=%0b p=%0b d=%0d ts=%0d lvl=%0d ovf=%0b miss=%0b, want v=%0b ev=%0b p=%0b d=%0d ts=%0d lvl=%0d ovf=%0b miss=%0b",
                     name, issue_valid, issue_event, issue_periodic, issue_data, issue_ts,
                     fifo_level, overflow, deadline_miss, v, ev, p, d, ts, lvl, o, m);
        end else begin
            $display("ok   %s: v=%0b ev=%0b p=%0b d=%0d ts=%0d lvl=%0d ovf=%0b miss=%0b",
                     name, issue_valid, issue_event, issue_periodic, issue_data, issue_ts,
                     fifo_level, overflow, deadline_miss);
        end
    endtask

    task automatic step(input logic ni, input logic [63:0] x, input logic rdy, input logic clr);
        new_input  = ni;
        input_x    = x;
        pipe_ready = rdy;
        clr_flags  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        new_input = 1'b0;
        input_x = '0;
        pipe_ready = 1'b0;
        clr_flags = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        en = 1'b1;
    endtask

    initial begin
        // Scenario A: ready always high; events at ts 2 and ts 7, deadlines at 7, 15, 23.
        for (int i = 0; i < 26; i++)
            tbl[i] = '{ni:1'b0, x:64'd0, rdy:1'b1, clr:1'b0, v:1'b0, ev:1'b0, p:1'b0,
                       d:64'd0, ts:32'd0, lvl:3'd0, o:1'b0, m:1'b0};
        tbl[2].ni = 1'b1; tbl[2].x = 64'd5; tbl[2].lvl = 3'd1;
        tbl[3].v = 1'b1; tbl[3].ev = 1'b1; tbl[3].d = 64'd5; tbl[3].ts = 32'd2; tbl[3].lvl = 3'd1;
        tbl[7].ni = 1'b1; tbl[7].x = 64'd6; tbl[7].lvl = 3'd1;
        tbl[8].v = 1'b1; tbl[8].ev = 1'b1; tbl[8].p = 1'b1; tbl[8].d = 64'd6; tbl[8].ts = 32'd7;
        tbl[8].lvl = 3'd1;
        tbl[16].v = 1'b1; tbl[16].p = 1'b1; tbl[16].ts = 32'd15;
        tbl[24].v = 1'b1; tbl[24].p = 1'b1; tbl[24].ts = 32'd23;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_out("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int e = 0; e < 26; e++) begin
            step(tbl[e].ni, tbl[e].x, tbl[e].rdy, tbl[e].clr);
            check_out($sformatf("A_edge%0d", e), tbl[e].v, tbl[e].ev, tbl[e].p, tbl[e].d,
                      tbl[e].ts, tbl[e].lvl, tbl[e].o, tbl[e].m);
        end

        // Scenario B: six events with ready low, DEPTH=4 -> two drops, then drain.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 64'(9 + i), 1'b0, (i == 5));
            if (i == 3) check_out("B_full", 1, 1, 0, 9, 0, 4, 0, 0);
            if (i == 4) check_out("B_drop", 1, 1, 0, 9, 0, 4, 1, 0);
            if (i == 5) check_out("B_ovf_beats_clr", 1, 1, 0, 9, 0, 4, 1, 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_out("B_hold_edge7", 1, 1, 0, 9, 0, 4, 1, 0);
        step(0, 0, 1, 0);
        check_out("B_drain10", 1, 1, 0, 10, 1, 3, 1, 0);
        step(0, 0, 1, 0);
        check_out("B_drain11", 1, 1, 0, 11, 2, 2, 1, 0);
        step(0, 0, 1, 0);
        check_out("B_drain12", 1, 1, 0, 12, 3, 1, 1, 0);
        step(0, 0, 1, 0);
        check_out("B_periodic7", 1, 0, 1, 0, 7, 0, 1, 0);
        step(0, 0, 1, 0);
        check_out("B_idle", 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1);
        check_out("B_clr_ovf", 0, 0, 0, 0, 0, 0, 0, 0);

        // Scenario C: consume at a firing edge is no miss; holding across a deadline is.
        do_reset();
        for (int e = 0; e <= 14; e++) begin
            step(0, 0, 0, 0);
            if (e == 8) check_out("C_periodic7", 1, 0, 1, 0, 7, 0, 0, 0);
        end
        check_out("C_hold7", 1, 0, 1, 0, 7, 0, 0, 0);
        step(0, 0, 1, 0);
        check_out("C_consume_at_fire", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_out("C_periodic15", 1, 0, 1, 0, 15, 0, 0, 0);
        for (int e = 17; e <= 23; e++) step(0, 0, 0, 0);
        check_out("C_miss", 1, 0, 1, 0, 15, 0, 0, 1);
        step(0, 0, 1, 0);
        check_out("C_after_miss", 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1);
        check_out("C_clr_miss", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int e = 26; e <= 30; e++) step(0, 0, 1, 0);
        check_out("C_lost_deadline", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0);
        check_out("C_fire31", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0);
        check_out("C_periodic31", 1, 0, 1, 0, 31, 0, 0, 0);

        // Scenario D: asynchronous reset mid-burst, then enable gating and ts restart.
        do_reset();
        step(1, 21, 0, 0);
        step(1, 22, 0, 0);
        step(1, 23, 0, 0);
        check_out("D_burst", 1, 1, 0, 21, 0, 3, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check_out("D_async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 99, 1, 0);
        check_out("D_en_low", 0, 0, 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        step(1, 77, 1, 0);
        check_out("D_enq77", 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0);
        check_out("D_ts_restart", 1, 1, 0, 77, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
